// File: rtl/ccff_bitstream_loader_if.sv
// Word-wide bitstream stream feeding the configuration chain loader.
// A word moves on a prog_clk edge where word_valid && word_ready.
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream words MSB-first into the fabric's configuration chain and tracks tail parity.
// First chain bit two cycles after start; each cycle stalled in FETCH holds the chain (prog_clk_en=0).
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 28
) (
  input  logic                   prog_clk,
  input  logic                   pReset,
  input  logic                   start,
  input  logic                   abort,
  ccff_bitstream_loader_if.slave s_word,
  output logic                   ccff_head,
  input  logic                   ccff_tail,
  output logic                   prog_clk_en,
  output logic                   busy,
  output logic                   done,
  output logic                   tail_parity
);
  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int BI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BL_W-1:0] LEN     = BL_W'(CHAIN_LEN);
  localparam logic [BI_W-1:0] IDX_TOP = BI_W'(WORD_W - 1);

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_sreg;
  logic [BL_W-1:0]   r_bits_left;
  logic [BI_W-1:0]   r_bit_idx;
  logic              r_par;
  logic              r_tail_parity;

  logic w_shift;
  logic w_last_bit;
  logic w_word_end;
  logic w_ready;

  assign w_shift    = (r_state == S_SHIFT) && !abort;
  assign w_last_bit = (r_bits_left == BL_W'(1));
  assign w_word_end = (r_bit_idx == '0);
  // Mid-load refill is offered only when bits remain beyond the word now draining.
  assign w_ready    = !abort && ((r_state == S_FETCH) ||
                                 ((r_state == S_SHIFT) && !w_last_bit && w_word_end));

  assign s_word.word_ready = w_ready;
  assign prog_clk_en       = w_shift;
  assign ccff_head         = w_shift & r_sreg[WORD_W-1];
  assign busy              = (r_state != S_IDLE);
  assign done              = (r_state == S_DONE) && !abort;
  assign tail_parity       = r_tail_parity;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state       <= S_IDLE;
      r_sreg        <= '0;
      r_bits_left   <= '0;
      r_bit_idx     <= '0;
      r_par         <= 1'b0;
      r_tail_parity <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_FETCH;
            r_bits_left <= LEN;
            r_par       <= 1'b0;
          end
        end
        S_FETCH: begin
          if (s_word.word_valid) begin
            r_sreg    <= s_word.word_in;
            r_bit_idx <= IDX_TOP;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bits_left <= r_bits_left - 1'b1;
          r_par       <= r_par ^ ccff_tail;
          if (w_last_bit) begin
            r_sreg    <= r_sreg << 1;
            r_bit_idx <= r_bit_idx - 1'b1;
            r_state   <= S_DONE;
          end else if (w_word_end && s_word.word_valid) begin
            r_sreg    <= s_word.word_in;
            r_bit_idx <= IDX_TOP;
          end else begin
            r_sreg    <= r_sreg << 1;
            r_bit_idx <= r_bit_idx - 1'b1;
            if (w_word_end) begin
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_tail_parity <= r_par;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench: drives word streams into the loader, models the chain, and checks against a behavioural reference.
module tb_ccff_bitstream_loader;
  localparam int W  = 8;
  localparam int L  = 28;
  localparam int NW = (L + W - 1) / W;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic pReset, start, abort, ccff_tail, ccff_head, prog_clk_en, busy, done, tail_parity;
  ccff_bitstream_loader_if #(.WORD_W(W)) wif ();

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort), .s_word(wif),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en),
    .busy(busy), .done(done), .tail_parity(tail_parity)
  );

  logic s_start, s_abort, s_head, s_tail, s_en, s_busy, s_done, s_tpar;
  ccff_bitstream_loader_if #(.WORD_W(8)) wif_s ();

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(3)) dut_s (
    .prog_clk(prog_clk), .pReset(pReset), .start(s_start), .abort(s_abort), .s_word(wif_s),
    .ccff_head(s_head), .ccff_tail(s_tail), .prog_clk_en(s_en),
    .busy(s_busy), .done(s_done), .tail_parity(s_tpar)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  always @(posedge prog_clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Fabric stand-in: the chain moves only on enabled edges, head enters at bit 0, tail leaves from the top.
  logic [L-1:0] chain, chain_preset;
  logic         chain_ld;
  always @(posedge prog_clk)
    if (chain_ld) chain <= chain_preset;
    else if (prog_clk_en) chain <= {chain[L-2:0], ccff_head};
  assign ccff_tail = chain[L-1];

  // Reference model: the chain must receive the words' bits MSB first, truncated to L,
  // and the parity reported is that of whatever the chain held when the load began.
  logic [W-1:0] cur_words [NW];
  bit           m_active = 1'b0;
  logic         m_par_exp = 1'b0;
  int           m_start, m_stall, m_en, m_xfer;
  logic [L-1:0] m_chain0;
  int           last_off, last_en, last_xfer;

  function automatic logic exp_bit(input int k);
    logic [W-1:0] w;
    w = cur_words[k / W];
    return w[W-1-(k % W)];
  endfunction

  function automatic logic [L-1:0] exp_chain();
    logic [L-1:0] v;
    for (int k = 0; k < L; k++) v[L-1-k] = exp_bit(k);
    return v;
  endfunction

  always @(negedge prog_clk) begin
    if (!pReset) begin
      m_active  = 1'b0;
      m_par_exp = 1'b0;
    end else begin
      chk("busy", 64'(busy), 64'(m_active));
      chk("tail_parity", 64'(tail_parity), 64'(m_par_exp));
      if (!prog_clk_en) chk("head_idle", 64'(ccff_head), 64'd0);
      if (abort) begin
        chk("abort_quiet", 64'({prog_clk_en, wif.word_ready, done}), 64'd0);
        m_active = 1'b0;
      end else begin
        if (prog_clk_en) begin
          chk("en_in_range", 64'(m_active && m_en < L && m_en < m_xfer * W), 64'd1);
          if (m_en < L && m_en < m_xfer * W) chk("head_bit", 64'(ccff_head), 64'(exp_bit(m_en)));
          m_en++;
        end
        if (wif.word_ready) begin
          chk("ready_word_count", 64'(m_active && m_xfer < NW), 64'd1);
          if (wif.word_valid) m_xfer++;
          else m_stall++;
        end
        if (done) begin
          chk("done_in_load", 64'(m_active), 64'd1);
          chk("done_cycle", 64'(cyc - m_start), 64'(L + 2 + m_stall));
          chk("done_enables", 64'(m_en), 64'(L));
          chk("done_words", 64'(m_xfer), 64'(NW));
          chk("chain_loaded", 64'(chain), 64'(exp_chain()));
          last_off  = cyc - m_start;
          last_en   = m_en;
          last_xfer = m_xfer;
          m_par_exp = ^m_chain0;
          m_active  = 1'b0;
        end else if (m_active && (cyc - m_start > L + 2 + m_stall)) begin
          chk("done_timeout", 64'(done), 64'd1);
          m_active = 1'b0;
        end
        if (!busy && start) begin
          m_active = 1'b1;
          m_start  = cyc;
          m_stall  = 0;
          m_en     = 0;
          m_xfer   = 0;
          m_chain0 = chain;
        end
      end
    end
  end

  task automatic preload(input logic [L-1:0] v);
    @(posedge prog_clk); #1;
    chain_preset = v;
    chain_ld     = 1'b1;
    @(posedge prog_clk); #1;
    chain_ld     = 1'b0;
  endtask

  // mode 0: valid held; 1: random valid and stray start pulses; 2: source stalls 3 ready cycles on word 2
  task automatic run_load(input int mode, input int abort_at, input int budget);
    int idx, stall2;
    bit fin, xfer;
    idx = 0; stall2 = 0; fin = 1'b0;
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    for (int c = 1; c <= budget && !fin; c++) begin
      abort = (c == abort_at);
      if (mode == 1) start = busy && ($urandom_range(0, 3) == 0);
      case (mode)
        1:       wif.word_valid = (idx < NW) && ($urandom_range(0, 3) != 0);
        2:       wif.word_valid = (idx < NW) && !(idx == 2 && stall2 < 3);
        default: wif.word_valid = (idx < NW);
      endcase
      wif.word_in = wif.word_valid ? cur_words[idx] : W'($urandom);
      @(negedge prog_clk);
      xfer = wif.word_valid && wif.word_ready;
      if (mode == 2 && idx == 2 && wif.word_ready && !wif.word_valid) stall2++;
      if (done) fin = 1'b1;
      if (abort_at != 0 && c > abort_at) fin = 1'b1;
      @(posedge prog_clk); #1;
      if (xfer) idx++;
    end
    abort = 1'b0;
    start = 1'b0;
    wif.word_valid = 1'b0;
    chk("load_finished", 64'(fin), 64'd1);
  endtask

  task automatic short_load(input logic [7:0] w, input logic [2:0] exp_bits);
    logic [2:0] got;
    int nen, nx, dc;
    got = '0; nen = 0; nx = 0; dc = -1;
    wif_s.word_in = w;
    wif_s.word_valid = 1'b1;
    @(posedge prog_clk); #1 s_start = 1'b1;
    @(posedge prog_clk); #1 s_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      s_start = (c == 2 || c == 3);
      @(negedge prog_clk);
      if (s_en) begin got = {got[1:0], s_head}; nen++; end
      if (wif_s.word_valid && wif_s.word_ready) nx++;
      if (s_done) dc = c;
      @(posedge prog_clk); #1;
    end
    s_start = 1'b0;
    chk("short_bits", 64'(got), 64'(exp_bits));
    chk("short_enables", 64'(nen), 64'd3);
    chk("short_transfers", 64'(nx), 64'd1);
    chk("short_done_cycle", 64'(dc), 64'd5);
    chk("short_idle_after", 64'(s_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pReset = 1'b0; start = 1'b0; abort = 1'b0;
    wif.word_valid = 1'b0; wif.word_in = '0;
    s_start = 1'b0; s_abort = 1'b0; s_tail = 1'b0;
    wif_s.word_valid = 1'b0; wif_s.word_in = '0;
    chain_ld = 1'b1; chain_preset = '0;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("reset_outputs", 64'({wif.word_ready, prog_clk_en, ccff_head, busy, done, tail_parity}), 64'd0);
    chk("reset_outputs_short", 64'({wif_s.word_ready, s_en, s_head, s_busy, s_done, s_tpar}), 64'd0);
    pReset = 1'b1;
    chain_ld = 1'b0;

    // Back-to-back load over a chain holding three ones
    preload(28'h0000007);
    cur_words = '{8'hA5, 8'h3C, 8'hFF, 8'h9F};
    run_load(0, 0, 100);
    chk("b2b_done_cycle", 64'(last_off), 64'd30);
    chk("b2b_transfers", 64'(last_xfer), 64'd4);
    chk("b2b_chain", 64'(chain), 64'h0A53CFF9);
    chk("b2b_parity", 64'(tail_parity), 64'd1);

    // Stalled source; chain now holds 0xA53CFF9 (18 ones)
    run_load(2, 0, 100);
    chk("stall_done_cycle", 64'(last_off), 64'd33);
    chk("stall_enables", 64'(last_en), 64'd28);
    chk("stall_chain", 64'(chain), 64'h0A53CFF9);
    chk("stall_parity", 64'(tail_parity), 64'd0);

    // Odd chain contents so the abort's parity hold is visible
    preload(28'h0000001);
    foreach (cur_words[i]) cur_words[i] = W'($urandom);
    run_load(0, 0, 100);
    chk("odd_parity", 64'(tail_parity), 64'd1);

    foreach (cur_words[i]) cur_words[i] = W'($urandom);
    run_load(0, 15, 100);
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_parity_held", 64'(tail_parity), 64'd1);
    run_load(0, 0, 100);
    chk("after_abort_done_cycle", 64'(last_off), 64'd30);

    repeat (12) begin
      if ($urandom_range(0, 1) == 1) preload(L'($urandom));
      foreach (cur_words[i]) cur_words[i] = W'($urandom);
      run_load(1, 0, 400);
    end

    // Asynchronous reset while shifting word 0
    foreach (cur_words[i]) cur_words[i] = W'($urandom);
    @(posedge prog_clk); #1;
    start = 1'b1;
    wif.word_valid = 1'b1;
    wif.word_in = cur_words[0];
    @(posedge prog_clk); #1 start = 1'b0;
    repeat (5) @(posedge prog_clk);
    #1;
    chk("rst_pre_shifting", 64'(prog_clk_en), 64'd1);
    #1 pReset = 1'b0;
    #1;
    chk("rst_async_outputs", 64'({wif.word_ready, prog_clk_en, ccff_head, busy, done, tail_parity}), 64'd0);
    @(posedge prog_clk); #1;
    pReset = 1'b1;
    wif.word_valid = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;

    short_load(8'hE0, 3'b111);
    short_load(8'h5F, 3'b010);
    short_load(8'hA0, 3'b101);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Serializes configuration words into the configuration flip-flop chain of the routing fabric (switch blocks, connection blocks, grids), driving `ccff_head` of the first chain element one bit per enabled cycle. It sits directly upstream of the chain, between the bitstream source (a word-wide valid/ready stream) and the chain. It also monitors `ccff_tail` of the last element, so software can check what the chain held before reprogramming.

## Interface
- `WORD_W`, 8: width of incoming bitstream words.
- `CHAIN_LEN`, 28: total chain length in bits (for example, 14 size-2 muxes × 2 SRAM bits); `CHAIN_LEN` ≥ 1.
- `prog_clk` input 1: programming clock; all state is on the rising edge.
- `pReset` input 1: asynchronous, active-low reset.
- `start` input 1: begin a load; sampled only in IDLE.
- `abort` input 1: cancel the load; highest priority.
- `word_in` input `WORD_W`: bitstream word, MSB shifted first.
- `word_valid` input 1: `word_in` is valid.
- `word_ready` output 1: loader accepts a word this cycle.
- `ccff_head` output 1: serial data to the chain head.
- `ccff_tail` input 1: serial data from the chain tail.
- `prog_clk_en` output 1: chain shift enable; the chain advances only on edges where it is 1.
- `busy` output 1: a load is in progress (any state except IDLE).
- `done` output 1: one-cycle pulse when the load completes.
- `tail_parity` output 1: XOR of all `ccff_tail` bits sampled during the last load.

## Operation
- **States:** IDLE, FETCH, SHIFT, DONE. Registers:
  - `sreg[WORD_W]`
  - `bits_left` (width ⌈log2(CHAIN_LEN+1)⌉)
  - `bit_idx` (width ⌈log2(WORD_W)⌉)
  - `par`
- **IDLE:** `word_ready`=0, `prog_clk_en`=0.
  - `start`=1 → FETCH.
  - Load `bits_left`=CHAIN_LEN and `par`=0.
- **FETCH:** `word_ready`=1.
  - On `word_valid`: `sreg`←`word_in`, `bit_idx`←WORD_W−1, go to SHIFT.
- **SHIFT:** `prog_clk_en`=1 and `ccff_head`=`sreg[WORD_W−1]`. On each edge:
  - `sreg`←`sreg`<<1
  - `bits_left`−1
  - `bit_idx`−1
  - `par`^=`ccff_tail`
- **Leaving SHIFT** (priority order):
  1. `bits_left`==1 → DONE. The rest of the current word is discarded.
  2. Else if `bit_idx`==0: `word_ready`=1 combinationally this cycle.
     - If `word_valid`: load the next word and stay in SHIFT (no bubble).
     - Otherwise go to FETCH.
- **DONE:** `done`=1 for one cycle; `tail_parity`←`par`; go to IDLE.
- **Word holding:** `tail_parity` holds its value until the next DONE.
- **Idle outputs:** `ccff_head`=0 whenever `prog_clk_en`=0.
- **Partial last word:** with CHAIN_LEN mod WORD_W = r ≠ 0, only the top r bits of the final word are used.
- **Word count:** exactly ⌈CHAIN_LEN/WORD_W⌉ words are accepted per load.
- **`abort`=1** in any state:
  - Next state is IDLE; nothing is captured or shifted on that edge.
  - `prog_clk_en`=0 and `word_ready`=0 combinationally in that cycle.
  - No `done` pulse; `tail_parity` is unchanged.
- **`start` outside IDLE:** ignored.

## Timing
- **Reset values:** state IDLE, `sreg`=0, `bits_left`=0, `bit_idx`=0, `par`=0, `tail_parity`=0. Outputs after reset:
  - `word_ready`=0, `prog_clk_en`=0, `ccff_head`=0
  - `busy`=0, `done`=0, `tail_parity`=0
- **Reset mid-load:** immediate IDLE; the chain is left partially shifted.
- **Latency with `word_valid` held high** (`start` sampled at edge 0):
  - FETCH during cycle 1.
  - First chain bit in cycle 2.
  - Last bit in cycle CHAIN_LEN+1.
  - `done` in cycle CHAIN_LEN+2.
- **Bubble rule:** each cycle spent waiting in FETCH adds one cycle with `prog_clk_en`=0. The bit sequence on `ccff_head` is unaffected.
- **Enable count:** exactly CHAIN_LEN cycles with `prog_clk_en`=1 per completed load.
- **Handshake:** a transfer occurs when `word_valid`&&`word_ready`.
  - `word_in` must be stable only on the transfer edge.
  - `word_ready` never asserts while `bits_left` ≤ bits still held in `sreg`.

## Test plan
- **Back-to-back load:** defaults, `start`, words 0xA5,0x3C,0xFF,0x9F with `word_valid` held.
  - `ccff_head` = 10100101 00111100 11111111 1001 over cycles 2..29.
  - `done` in cycle 30; 4 transfers.
- **Stalled source:** `word_valid` dropped for 3 cycles before word 2.
  - Same bit sequence; `prog_clk_en` low for exactly 3 cycles; `done` in cycle 33.
- **Tail parity:** `ccff_tail` driven by a 28-bit shift-register model preloaded with 0x0000007 (three ones).
  - `tail_parity`=1 after `done`; a second load with 0xA5-derived contents matches the model XOR.
- **Abort:** `abort` in cycle 15.
  - `prog_clk_en`=0 from cycle 15; state IDLE; no `done`; `tail_parity` keeps its prior value.
  - A new `start` then completes normally.
- **Async reset mid-SHIFT:** `pReset`=0 between edges.
  - All outputs at reset values immediately, before the next edge.
- **Short chain:** CHAIN_LEN=3, WORD_W=8, word 0xE0.
  - Bits 1,1,1; one transfer; `done` in cycle 5; `start` pulsed during busy is ignored.
